// File: rtl/rr_mux_nto1_pkt_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_nto1_pkt_if
//  Description : Bundle of the N source channels and the single destination
//                channel of the round-robin packet mux. The mux itself uses
//                the slave view. Whatever drives the sources and sinks the
//                destination uses the master view.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_mux_nto1_pkt_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
);

  // Source side: one valid/ready/last lane per channel, payloads flattened
  logic [N-1:0]   vld_src;
  logic [N*W-1:0] pld_src;
  logic [N-1:0]   last_src;
  logic [N-1:0]   rdy_src;

  // Destination side: registered beat plus the index of its source
  logic           vld_dst;
  logic [W-1:0]   pld_dst;
  logic           last_dst;
  logic [IDW-1:0] gnt_dst;
  logic           rdy_dst;

  // Status: a packet is in progress and its grant is held
  logic           locked;

  modport master (
    output vld_src, pld_src, last_src, rdy_dst,
    input  rdy_src, vld_dst, pld_dst, last_dst, gnt_dst, locked
  );

  modport slave (
    input  vld_src, pld_src, last_src, rdy_dst,
    output rdy_src, vld_dst, pld_dst, last_dst, gnt_dst, locked
  );

endinterface
`default_nettype wire

// File: rtl/rr_mux_nto1_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_nto1_pkt
//  Description : N-to-1 round-robin arbitrating mux with a registered output
//                stage and packet locking. Multi-beat packets, delimited by
//                last, are never interleaved. Fairness is per packet: the
//                priority pointer only moves when a last beat is taken.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_mux_nto1_pkt #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  rr_mux_nto1_pkt_if.slave bus
);

  localparam logic [IDW:0]   c_n_ext    = (IDW+1)'(N);
  localparam logic [IDW-1:0] c_last_idx = IDW'(N - 1);

  // Registered state
  logic [IDW-1:0] r_ptr;       // highest-priority source when unlocked
  logic           r_locked;    // mid-packet: grant is pinned to r_lock_id
  logic [IDW-1:0] r_lock_id;
  logic           r_vld;
  logic [W-1:0]   r_pld;
  logic           r_last;
  logic [IDW-1:0] r_gnt;

  // Combinational arbitration results
  logic [W-1:0]   w_pld_arr [N];
  logic [IDW:0]   w_scan;
  logic [IDW-1:0] w_pick;
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic           w_req;
  logic           w_load;
  logic           w_xfer;
  logic           w_win_last;
  logic [W-1:0]   w_win_pld;
  logic [IDW-1:0] w_ptr_nxt;
  logic [N-1:0]   w_lock_mask;

  // Unflatten the payload bus so the winner can be selected by index
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_pld_arr[gi] = bus.pld_src[gi*W +: W];
  end

  // The output slot can take a new beat when empty or when its beat leaves
  assign w_load = ~r_vld | bus.rdy_dst;

  // Cyclic first-valid search starting at r_ptr, wrapping modulo N
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= c_n_ext) begin
        w_scan = w_scan - c_n_ext;
      end
      if (!w_found && bus.vld_src[w_scan[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[IDW-1:0];
      end
    end
  end

  // While locked only the owning source may be served, even if it is idle.
  // Reset masks the request so no source sees ready during reset.
  assign w_winner   = r_locked ? r_lock_id : w_pick;
  assign w_req      = ~rst & (r_locked ? bus.vld_src[r_lock_id] : w_found);
  assign w_xfer     = w_load & w_req;
  assign w_win_last = bus.last_src[w_winner];
  assign w_win_pld  = w_pld_arr[w_winner];
  assign w_ptr_nxt  = (w_winner == c_last_idx) ? '0 : w_winner + 1'b1;

  // At most one ready bit, and only for the winner
  for (genvar gi = 0; gi < N; gi++) begin : g_rdy
    assign bus.rdy_src[gi] = w_xfer & (w_winner == IDW'(gi));
  end

  // Output register stage: load on transfer, drain when empty-and-idle, hold
  // under back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_pld  <= '0;
      r_last <= 1'b0;
      r_gnt  <= '0;
    end else if (w_load) begin
      r_vld <= w_xfer;
      if (w_xfer) begin
        r_pld  <= w_win_pld;
        r_last <= w_win_last;
        r_gnt  <= w_winner;
      end
    end
  end

  // Packet lock: a non-last beat pins the grant, a last beat releases it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_xfer) begin
      r_locked  <= ~w_win_last;
      r_lock_id <= w_winner;
    end
  end

  // Priority pointer advances past the winner only at packet end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer && w_win_last) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign bus.vld_dst  = r_vld;
  assign bus.pld_dst  = r_pld;
  assign bus.last_dst = r_last;
  assign bus.gnt_dst  = r_gnt;
  assign bus.locked   = r_locked;

  // Ready vector bit belonging to the lock owner
  assign w_lock_mask = {{(N-1){1'b0}}, 1'b1} << r_lock_id;

  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.rdy_src));

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.vld_dst && !bus.rdy_dst) |=>
      (bus.vld_dst && $stable(bus.pld_dst) && $stable(bus.last_dst) &&
       $stable(bus.gnt_dst)));

  a_lock_only : assert property (@(posedge clk) disable iff (rst)
    r_locked |-> ((bus.vld_src & bus.rdy_src & ~w_lock_mask) == '0));

endmodule
`default_nettype wire
